// File: rtl/iir_coef_pkg.sv
// Shared definitions for the IIR coefficient loader.
// Holds the loader state encoding, the err_code values, the default frame
// start byte and a helper that validates the COUNT byte of a frame.
package iir_coef_pkg;

  // Loader states, one per phase of a frame
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    COUNT  = 3'd1,
    DATA   = 3'd2,
    CHECK  = 3'd3,
    COMMIT = 3'd4,
    DONE   = 3'd5
  } state_e;

  // err_code values
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_CHECKSUM = 2'd1;
  localparam logic [1:0] ERR_COUNT    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  // Default frame start byte
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // Size of the shadow buffer; the largest legal NUM_COEF
  localparam int MAX_COEF = 8;

  // A COUNT byte is usable when it is 1..max_coef
  function automatic logic count_ok(input logic [7:0] cnt, input int max_coef);
    return (cnt != 8'd0) && (cnt <= 8'(max_coef));
  endfunction

endpackage

// File: rtl/iir_coef_loader_gap_timer.sv
// Byte-gap timer for the coefficient loader.
// Counts clk cycles while run is high; clear (or run low) restarts it at 0.
// expired is high once TIMEOUT cycles have elapsed without a clear.
// Ports: clk, reset_l (async active-low), clear, run -> expired.
module coef_gap_timer
#(
  parameter int TIMEOUT = 50_000
)
(
  input  logic clk,
  input  logic reset_l,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_r;

  // Gap counter: restart on clear or when idle, saturate at TIMEOUT
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      cnt_r <= '0;
    end else if (clear || !run) begin
      cnt_r <= '0;
    end else if (cnt_r != CNT_W'(TIMEOUT)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == CNT_W'(TIMEOUT));

endmodule

// File: rtl/iir_coef_loader.sv
// IIR coefficient loader.
// Receives frames SYNC, COUNT, COUNT x 4 big-endian coefficient bytes, CHK
// over a valid/ready byte stream, verifies the XOR checksum and then writes
// the words to the filter one per cycle (enabel/address/data).
// Ports:
//   clk, reset_l            clock, async active-low reset
//   rx_data, rx_valid       incoming byte stream
//   rx_ready                loader accepts a byte this cycle
//   address, data, enabel   coefficient write port (held while enabel low)
//   coef_valid              a complete set has been committed
//   load_done               one-cycle pulse at the end of a commit
//   err, err_code           one-cycle reject pulse and its reason
module iir_coef_loader
  import iir_coef_pkg::*;
#(
  parameter int         NUM_COEF = 5,
  parameter int         TIMEOUT  = 50_000,
  parameter logic [7:0] SYNC     = SYNC_DEFAULT
)
(
  input  logic        clk,
  input  logic        reset_l,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [2:0]  address,
  output logic [31:0] data,
  output logic        enabel,
  output logic        coef_valid,
  output logic        load_done,
  output logic        err,
  output logic [1:0]  err_code
);

  state_e      state_r;
  logic        rx_ready_r;
  logic        enabel_r;
  logic        coef_valid_r;
  logic        load_done_r;
  logic        err_r;
  logic [1:0]  err_code_r;
  logic [2:0]  address_r;
  logic [31:0] data_r;
  logic [3:0]  count_r;
  logic [2:0]  word_idx_r;
  logic [1:0]  byte_idx_r;
  logic [3:0]  commit_idx_r;
  logic [7:0]  xor_r;
  logic [31:0] shadow_r [MAX_COEF];

  logic accept_s;
  logic run_s;
  logic expired_s;

  assign accept_s = rx_valid && rx_ready_r;
  assign run_s    = (state_r == COUNT) || (state_r == DATA) || (state_r == CHECK);

  coef_gap_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_gap_timer (
    .clk     (clk),
    .reset_l (reset_l),
    .clear   (accept_s),
    .run     (run_s),
    .expired (expired_s)
  );

  // Frame FSM with all outputs registered
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_r      <= IDLE;
      rx_ready_r   <= 1'b0;
      enabel_r     <= 1'b0;
      coef_valid_r <= 1'b0;
      load_done_r  <= 1'b0;
      err_r        <= 1'b0;
      err_code_r   <= ERR_NONE;
      address_r    <= 3'd0;
      data_r       <= 32'd0;
      count_r      <= 4'd0;
      word_idx_r   <= 3'd0;
      byte_idx_r   <= 2'd0;
      commit_idx_r <= 4'd0;
      xor_r        <= 8'd0;
      for (int i = 0; i < MAX_COEF; i++) begin
        shadow_r[i] <= 32'd0;
      end
    end else begin
      enabel_r    <= 1'b0;
      load_done_r <= 1'b0;
      err_r       <= 1'b0;
      // A stalled frame is dropped regardless of the phase it stalled in
      if (run_s && expired_s) begin
        err_r      <= 1'b1;
        err_code_r <= ERR_TIMEOUT;
        state_r    <= IDLE;
        rx_ready_r <= 1'b1;
      end else begin
        case (state_r)
          IDLE: begin
            rx_ready_r <= 1'b1;
            // Anything other than SYNC is swallowed here
            if (accept_s && (rx_data == SYNC)) begin
              state_r    <= COUNT;
              err_code_r <= ERR_NONE;
              xor_r      <= 8'd0;
              word_idx_r <= 3'd0;
              byte_idx_r <= 2'd0;
            end
          end
          COUNT: begin
            if (accept_s) begin
              if (count_ok(rx_data, NUM_COEF)) begin
                count_r <= rx_data[3:0];
                xor_r   <= rx_data;
                state_r <= DATA;
              end else begin
                err_r      <= 1'b1;
                err_code_r <= ERR_COUNT;
                state_r    <= IDLE;
              end
            end
          end
          DATA: begin
            if (accept_s) begin
              // Big-endian: earlier bytes shift toward the MSB
              shadow_r[word_idx_r] <= {shadow_r[word_idx_r][23:0], rx_data};
              xor_r                <= xor_r ^ rx_data;
              if (byte_idx_r == 2'd3) begin
                byte_idx_r <= 2'd0;
                if ({1'b0, word_idx_r} == (count_r - 4'd1)) begin
                  word_idx_r <= 3'd0;
                  state_r    <= CHECK;
                end else begin
                  word_idx_r <= word_idx_r + 3'd1;
                end
              end else begin
                byte_idx_r <= byte_idx_r + 2'd1;
              end
            end
          end
          CHECK: begin
            if (accept_s) begin
              if (rx_data == xor_r) begin
                // Word 0 goes out in the cycle right after CHK
                state_r      <= COMMIT;
                rx_ready_r   <= 1'b0;
                enabel_r     <= 1'b1;
                address_r    <= 3'd0;
                data_r       <= shadow_r[0];
                commit_idx_r <= 4'd1;
              end else begin
                err_r      <= 1'b1;
                err_code_r <= ERR_CHECKSUM;
                state_r    <= IDLE;
              end
            end
          end
          COMMIT: begin
            rx_ready_r <= 1'b0;
            if (commit_idx_r < count_r) begin
              enabel_r     <= 1'b1;
              address_r    <= commit_idx_r[2:0];
              data_r       <= shadow_r[commit_idx_r[2:0]];
              commit_idx_r <= commit_idx_r + 4'd1;
            end else begin
              state_r      <= DONE;
              load_done_r  <= 1'b1;
              coef_valid_r <= 1'b1;
            end
          end
          DONE: begin
            state_r    <= IDLE;
            rx_ready_r <= 1'b1;
          end
          default: begin
            state_r    <= IDLE;
            rx_ready_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx_ready   = rx_ready_r;
  assign enabel     = enabel_r;
  assign address    = address_r;
  assign data       = data_r;
  assign coef_valid = coef_valid_r;
  assign load_done  = load_done_r;
  assign err        = err_r;
  assign err_code   = err_code_r;

endmodule

// File: doc/iir_coef_loader.md
IIR_COEF_LOADER -- requirements
Module: iir_coef_loader

Interface
REQ-001 Parameter NUM_COEF, default 5, sets the maximum number of coefficients per frame; legal range is 1..8.
REQ-002 Parameter TIMEOUT, default 50_000, sets the maximum number of clk cycles allowed between accepted bytes inside a frame.
REQ-003 Parameter SYNC, default 8'hA5, is the frame start byte.
REQ-004 Port clk, input, 1 bit: clock; all logic is on the rising edge.
REQ-005 Port reset_l, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port rx_data, input, 8 bits: incoming byte.
REQ-007 Port rx_valid, input, 1 bit: rx_data is valid.
REQ-008 Port rx_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-009 Port address, output, 3 bits: filter coefficient index.
REQ-010 Port data, output, 32 bits: IEEE-754 single-precision coefficient.
REQ-011 Port enabel, output, 1 bit: coefficient write strobe, one cycle per word.
REQ-012 Port coef_valid, output, 1 bit: a complete coefficient set has been committed.
REQ-013 Port load_done, output, 1 bit: one-cycle pulse when a commit finishes.
REQ-014 Port err, output, 1 bit: one-cycle pulse when a frame is rejected.
REQ-015 Port err_code, output, 2 bits: 0 none, 1 checksum, 2 bad count, 3 timeout.

Function
REQ-016 A byte SHALL be accepted only in a cycle where rx_valid and rx_ready are both high.
REQ-017 The frame format SHALL be: SYNC, COUNT, COUNT×4 coefficient bytes (big-endian), CHK.
REQ-018 CHK SHALL equal the XOR of COUNT and all coefficient bytes; SYNC is excluded from the checksum.
REQ-019 The FSM states SHALL be IDLE, COUNT, DATA, CHECK, COMMIT and DONE.
REQ-020 In IDLE, non-SYNC bytes SHALL be accepted and discarded; an accepted SYNC byte moves the FSM to COUNT and clears err_code.
REQ-021 In COUNT, an accepted byte of 0 or greater than NUM_COEF SHALL trigger an err pulse with err_code=2 and a return to IDLE; any other value is latched and the FSM moves to DATA.
REQ-022 In DATA, bytes SHALL be shifted into a shadow buffer indexed by a word counter and a byte counter; after byte COUNT×4 is accepted the FSM moves to CHECK.
REQ-023 In CHECK, the accepted byte SHALL be compared with the running XOR; on mismatch the loader pulses err with err_code=2'd1 and returns to IDLE; on match it moves to COMMIT.
REQ-024 On any checksum or count failure, no enabel pulse SHALL occur, and the previously committed coefficients and coef_valid SHALL remain unchanged.
REQ-025 In COMMIT, rx_ready SHALL be 0, and enabel SHALL be high for COUNT consecutive cycles with address = 0..COUNT-1 and data = the matching shadow word.
REQ-026 Commit latency: the first enabel SHALL occur in the cycle after CHK is accepted.
REQ-027 In DONE, which lasts exactly 1 cycle, load_done SHALL pulse, coef_valid SHALL be set to 1, and the FSM returns to IDLE.
REQ-028 In COUNT, DATA and CHECK, the gap counter SHALL reset on each accepted byte; when it reaches TIMEOUT the loader pulses err with err_code=3 and returns to IDLE.
REQ-029 rx_ready SHALL be 1 in IDLE, COUNT, DATA and CHECK, and 0 in COMMIT and DONE.
REQ-030 A SYNC value received mid-frame SHALL be treated as data; there is no resynchronisation inside a frame.
REQ-031 address and data SHALL hold their last driven values while enabel is low.

Reset
REQ-032 While reset_l is low, the FSM SHALL be in IDLE, and rx_ready, enabel, load_done, err and coef_valid SHALL be 0.
REQ-033 While reset_l is low, address, data, err_code, all counters, the running XOR and the shadow buffer SHALL be 0.
REQ-034 Reset asserted mid-frame or mid-commit SHALL abort immediately with no further enabel; there is no partial-commit recovery.

Structure
REQ-035 A shared package iir_coef_pkg SHALL hold the state enum, the err_code constants and the SYNC default.
REQ-036 The byte-gap timeout counter SHALL be the single sub-module, coef_gap_timer (inputs: clear, run; output: expired).

Verification
REQ-037 Frame A5 02 3F 80 00 00 40 00 00 00 FD -> enabel addr0=32'h3F800000, then addr1=32'h40000000 on consecutive cycles; load_done one cycle later; coef_valid=1.
REQ-038 The same frame with CHK=FE -> err pulse, err_code=1, no enabel, coef_valid unchanged.
REQ-039 Frame A5 06 (NUM_COEF=5) -> err pulse, err_code=2, FSM back in IDLE; a following valid frame is loaded correctly.
REQ-040 Frame A5 01 3F 80 followed by TIMEOUT idle cycles -> err pulse, err_code=3, no enabel.
REQ-041 Bytes 00 FF 12 then a valid one-coefficient frame -> the leading bytes are ignored and a single enabel occurs at addr0.
REQ-042 reset_l pulled low during the second COMMIT cycle of a 4-coefficient frame -> enabel drops immediately and all outputs take their reset values.
